// File: rtl/tc_readback_pkg.sv
// rtl/tc_readback_pkg.sv - shared sizes, select codes and FSM states for the timer/counter read port
//
// Purpose: constants used by tc_readback and tc_event_flags.
//   tcNumbers   number of timers/counters
//   tcAddrLen   timer/counter address width
//   tcPresetLen preset width
//   tcAccLen    accumulator width (same as preset width)
//   tcRdSel*    read field select codes
//   rdState_e   read FSM state codes
// Ports: none (package).
package tc_readback_pkg;

  localparam int tcNumbers   = 16;
  localparam int tcAddrLen   = 4;
  localparam int tcPresetLen = 8;
  localparam int tcAccLen    = 8;

  localparam logic [1:0] tcRdSelPreset = 2'b00;
  localparam logic [1:0] tcRdSelAcc    = 2'b01;
  localparam logic [1:0] tcRdSelStat   = 2'b10;
  localparam logic [1:0] tcRdSelEvt    = 2'b11;

  typedef enum logic [1:0] {
    rdIdle    = 2'b00,
    rdCapture = 2'b01,
    rdDrive   = 2'b10
  } rdState_e;

endpackage

// File: rtl/tc_event_flags.sv
// rtl/tc_event_flags.sv - sticky per-timer "done rose" flags with OR summary
//
// Purpose: registers the done history, detects 0->1 edges, keeps sticky flags that are
// cleared by clrIn, and produces a registered OR of all flags.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   doneIn    in   per-timer done bits
//   clrIn     in   per-flag clear (external write-one-to-clear merged with read clear)
//   flags     out  sticky flags
//   eventAny  out  OR of flags, one cycle behind them
import tc_readback_pkg::*;

module tc_event_flags #(
  parameter int TC_NUM = tcNumbers
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TC_NUM-1:0] doneIn,
  input  logic [TC_NUM-1:0] clrIn,
  output logic [TC_NUM-1:0] flags,
  output logic              eventAny
);

  logic [TC_NUM-1:0] doneHist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      doneHist <= '0;
      flags    <= '0;
      eventAny <= 1'b0;
    end else begin
      doneHist <= doneIn;
      // a rising edge outranks a clear arriving in the same cycle
      flags    <= (flags & ~clrIn) | (doneIn & ~doneHist);
      eventAny <= |flags;
    end
  end

endmodule

// File: rtl/tc_readback.sv
// rtl/tc_readback.sv - processor read port for the timer/counter bank
//
// Purpose: request/valid read of one timer's preset, accumulated value, status or sticky
// event-flag byte. Request accepted in IDLE, field sampled at the CAPTURE edge, result
// presented with a one-cycle tcRdValid at the DRIVE edge.
// Optional feature: TC_RD_CLR_ON_READ_EN makes event-flag reads clear the returned byte.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   tcRdReq     in   read request (ignored while tcRdBusy)
//   tcRdSel     in   field select: preset / accumulated / status / event flags
//   tcRdAddr    in   timer index (event flags: bit0 picks the byte)
//   presetIn    in   flattened presets
//   accIn       in   flattened accumulated values
//   doneIn      in   per-timer done bits
//   enIn        in   per-timer enable bits
//   tcEvClr     in   write-one-to-clear for sticky flags
//   tcRdBusy    out  high during CAPTURE and DRIVE
//   tcRdValid   out  one-cycle result strobe
//   tcRdData    out  read result, held until the next strobe
//   tcEventAny  out  registered OR of all sticky flags
import tc_readback_pkg::*;

module tc_readback #(
  parameter int TC_NUM = tcNumbers,
  parameter int ADDR_W = tcAddrLen,
  parameter int DATA_W = tcPresetLen
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tcRdReq,
  input  logic [1:0]               tcRdSel,
  input  logic [ADDR_W-1:0]        tcRdAddr,
  input  logic [DATA_W*TC_NUM-1:0] presetIn,
  input  logic [DATA_W*TC_NUM-1:0] accIn,
  input  logic [TC_NUM-1:0]        doneIn,
  input  logic [TC_NUM-1:0]        enIn,
  input  logic [TC_NUM-1:0]        tcEvClr,
  output logic                     tcRdBusy,
  output logic                     tcRdValid,
  output logic [DATA_W-1:0]        tcRdData,
  output logic                     tcEventAny
);

  // flags are viewed as at least two bytes so the byte select never runs off the end
  localparam int FLAG_W = (TC_NUM > 2*DATA_W) ? TC_NUM : 2*DATA_W;

  rdState_e          state;
  logic [1:0]        selQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] holdQ;
  logic [DATA_W-1:0] field;
  logic [TC_NUM-1:0] flags;
  logic [TC_NUM-1:0] rdClr;
  logic [FLAG_W-1:0] flagsPad;
  int                addrIdx;

  assign addrIdx = int'(addrQ);

  tc_event_flags #(.TC_NUM(TC_NUM)) uFlags (
    .clk      (clk),
    .reset    (reset),
    .doneIn   (doneIn),
    .clrIn    (tcEvClr | rdClr),
    .flags    (flags),
    .eventAny (tcEventAny)
  );

  always_comb begin
    flagsPad              = '0;
    flagsPad[TC_NUM-1:0]  = flags;
  end

  // Field mux over the latched select/address; out-of-range addresses read as zero
  // because no loop index matches them.
  always_comb begin
    field = '0;
    case (selQ)
      tcRdSelPreset: begin
        for (int i = 0; i < TC_NUM; i++)
          if (addrIdx == i) field = presetIn[DATA_W*i +: DATA_W];
      end
      tcRdSelAcc: begin
        for (int i = 0; i < TC_NUM; i++)
          if (addrIdx == i) field = accIn[DATA_W*i +: DATA_W];
      end
      tcRdSelStat: begin
        for (int i = 0; i < TC_NUM; i++)
          if (addrIdx == i) begin
            field[1] = enIn[i];
            field[0] = doneIn[i];
          end
      end
      default: begin
        if (addrIdx < TC_NUM) begin
          for (int b = 0; b < 2; b++)
            if (int'(addrQ[0]) == b) field = flagsPad[DATA_W*b +: DATA_W];
        end
      end
    endcase
  end

  always_comb begin
    rdClr = '0;
`ifdef TC_RD_CLR_ON_READ_EN
    if (state == rdCapture && selQ == tcRdSelEvt && addrIdx < TC_NUM) begin
      for (int i = 0; i < TC_NUM; i++)
        if (i / DATA_W == int'(addrQ[0])) rdClr[i] = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= rdIdle;
      selQ      <= '0;
      addrQ     <= '0;
      holdQ     <= '0;
      tcRdBusy  <= 1'b0;
      tcRdValid <= 1'b0;
      tcRdData  <= '0;
    end else begin
      tcRdValid <= 1'b0;
      case (state)
        rdIdle: begin
          if (tcRdReq) begin
            selQ     <= tcRdSel;
            addrQ    <= tcRdAddr;
            tcRdBusy <= 1'b1;
            state    <= rdCapture;
          end
        end
        rdCapture: begin
          holdQ <= field;
          state <= rdDrive;
        end
        rdDrive: begin
          tcRdData  <= holdQ;
          tcRdValid <= 1'b1;
          tcRdBusy  <= 1'b0;
          state     <= rdIdle;
        end
        default: begin
          tcRdBusy <= 1'b0;
          state    <= rdIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_readback.sv
// tb/tb_tc_readback.sv - randomized self-checking bench for tc_readback
module tb_tc_readback;

  localparam int TC_NUM = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     tcRdReq = 1'b0;
  logic [1:0]               tcRdSel = '0;
  logic [ADDR_W-1:0]        tcRdAddr = '0;
  logic [DATA_W*TC_NUM-1:0] presetIn;
  logic [DATA_W*TC_NUM-1:0] accIn;
  logic [TC_NUM-1:0]        doneIn = '0;
  logic [TC_NUM-1:0]        enIn = '0;
  logic [TC_NUM-1:0]        tcEvClr = '0;
  logic                     tcRdBusy;
  logic                     tcRdValid;
  logic [DATA_W-1:0]        tcRdData;
  logic                     tcEventAny;

  logic [DATA_W-1:0] presetArr [TC_NUM];
  logic [DATA_W-1:0] accArr    [TC_NUM];

  // reference model state
  bit                mFlags [TC_NUM];
  bit                mPrev  [TC_NUM];
  bit                mAny;
  logic [TC_NUM-1:0] pendRdClr = '0;

  int nCompared = 0;
  int nMismatched = 0;

  tc_readback #(.TC_NUM(TC_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .tcRdReq    (tcRdReq),
    .tcRdSel    (tcRdSel),
    .tcRdAddr   (tcRdAddr),
    .presetIn   (presetIn),
    .accIn      (accIn),
    .doneIn     (doneIn),
    .enIn       (enIn),
    .tcEvClr    (tcEvClr),
    .tcRdBusy   (tcRdBusy),
    .tcRdValid  (tcRdValid),
    .tcRdData   (tcRdData),
    .tcEventAny (tcEventAny)
  );

  always #5 clk = ~clk;

  always_comb begin
    presetIn = '0;
    accIn    = '0;
    for (int i = 0; i < TC_NUM; i++) begin
      presetIn[DATA_W*i +: DATA_W] = presetArr[i];
      accIn[DATA_W*i +: DATA_W]    = accArr[i];
    end
  end

  // Sticky-flag model: a flag goes up when its done bit is seen rising between two edges,
  // otherwise a clear request drops it; the summary bit reports the previous flag set.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TC_NUM; i++) begin
        mFlags[i] = 1'b0;
        mPrev[i]  = 1'b0;
      end
      mAny = 1'b0;
    end else begin
      bit anyOld;
      anyOld = 1'b0;
      for (int i = 0; i < TC_NUM; i++) anyOld = anyOld | mFlags[i];
      for (int i = 0; i < TC_NUM; i++) begin
        if (doneIn[i] && !mPrev[i]) mFlags[i] = 1'b1;
        else if (tcEvClr[i] || pendRdClr[i]) mFlags[i] = 1'b0;
        mPrev[i] = doneIn[i];
      end
      mAny = anyOld;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] refRead(input logic [1:0] sel, input int addr);
    logic [DATA_W-1:0] r;
    r = '0;
    if (addr < TC_NUM) begin
      case (sel)
        2'b00: r = presetArr[addr];
        2'b01: r = accArr[addr];
        2'b10: r = DATA_W'(2 * int'(enIn[addr]) + int'(doneIn[addr]));
        default: begin
          for (int k = 0; k < DATA_W; k++) begin
            int idx;
            idx = (addr % 2) * DATA_W + k;
            if (idx < TC_NUM) r[k] = mFlags[idx];
          end
        end
      endcase
    end
    return r;
  endfunction

  function automatic logic [TC_NUM-1:0] byteMask(input int addr);
    logic [TC_NUM-1:0] m;
    m = '0;
    for (int k = 0; k < DATA_W; k++) begin
      int idx;
      idx = (addr % 2) * DATA_W + k;
      if (idx < TC_NUM) m[idx] = 1'b1;
    end
    return m;
  endfunction

  // One read with fixed timing: valid must appear exactly two edges after acceptance.
  task automatic doRead(input logic [1:0] sel, input int addr, input string tag);
    logic [DATA_W-1:0] want;
    @(negedge clk);
    tcRdReq  = 1'b1;
    tcRdSel  = sel;
    tcRdAddr = ADDR_W'(addr);
    @(negedge clk);
    tcRdReq = 1'b0;
    checkVal({tag, "_busy_a"}, 32'(tcRdBusy), 32'd1);
    want = refRead(sel, addr);
`ifdef TC_RD_CLR_ON_READ_EN
    if (sel == 2'b11) pendRdClr = byteMask(addr);
`endif
    @(negedge clk);
    pendRdClr = '0;
    checkVal({tag, "_busy_b"}, 32'(tcRdBusy), 32'd1);
    checkVal({tag, "_early_valid"}, 32'(tcRdValid), 32'd0);
    @(negedge clk);
    checkVal({tag, "_valid"}, 32'(tcRdValid), 32'd1);
    checkVal({tag, "_busy_end"}, 32'(tcRdBusy), 32'd0);
    checkVal({tag, "_data"}, 32'(tcRdData), 32'(want));
  endtask

  initial begin
    int vCount;
    logic [DATA_W-1:0] held;
    for (int i = 0; i < TC_NUM; i++) begin
      presetArr[i] = '0;
      accArr[i]    = '0;
    end

    // reset held with random activity on the inputs
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tcRdReq = 1'(($urandom));
      tcRdSel = 2'($urandom);
      tcRdAddr = ADDR_W'($urandom);
      doneIn  = TC_NUM'($urandom);
      enIn    = TC_NUM'($urandom);
      tcEvClr = TC_NUM'($urandom);
      #1;
      checkVal("rst_busy", 32'(tcRdBusy), 32'd0);
      checkVal("rst_valid", 32'(tcRdValid), 32'd0);
      checkVal("rst_data", 32'(tcRdData), 32'd0);
      checkVal("rst_any", 32'(tcEventAny), 32'd0);
    end
    @(negedge clk);
    tcRdReq = 1'b0; doneIn = '0; enIn = '0; tcEvClr = '0;
    reset = 1'b1;
    @(negedge clk);
    checkVal("post_rst_busy", 32'(tcRdBusy), 32'd0);
    checkVal("post_rst_any", 32'(tcEventAny), 32'd0);

    // preset read
    presetArr[5] = 8'hA7;
    doRead(2'b00, 5, "preset5");
    checkVal("preset5_const", 32'(tcRdData), 32'h0A7);

    // second request while busy is dropped
    accArr[3] = 8'h12;
    accArr[9] = 8'h34;
    @(negedge clk);
    tcRdReq = 1'b1; tcRdSel = 2'b01; tcRdAddr = 4'd3;
    @(negedge clk);
    tcRdAddr = 4'd9;
    checkVal("drop_busy", 32'(tcRdBusy), 32'd1);
    @(negedge clk);
    tcRdReq = 1'b0;
    checkVal("drop_no_valid", 32'(tcRdValid), 32'd0);
    @(negedge clk);
    checkVal("drop_valid", 32'(tcRdValid), 32'd1);
    checkVal("drop_data", 32'(tcRdData), 32'h012);
    vCount = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (tcRdValid) vCount++;
    end
    checkVal("drop_extra_valid", 32'(vCount), 32'd0);

    // sticky event on timer 10
    @(negedge clk);
    doneIn[10] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkVal("ev_any", 32'(tcEventAny), 32'd1);
    doRead(2'b11, 1, "ev_rd1");
    checkVal("ev_rd1_const", 32'(tcRdData), 32'h004);
    doRead(2'b11, 1, "ev_rd2");
`ifdef TC_RD_CLR_ON_READ_EN
    checkVal("ev_rd2_const", 32'(tcRdData), 32'h000);
`else
    checkVal("ev_rd2_const", 32'(tcRdData), 32'h004);
`endif
    @(negedge clk);
    tcEvClr[10] = 1'b1;
    @(negedge clk);
    tcEvClr = '0;
    doRead(2'b11, 1, "ev_rd3");
    checkVal("ev_rd3_const", 32'(tcRdData), 32'h000);

    // rising done and clear in the same cycle: set wins
    @(negedge clk);
    doneIn[2]  = 1'b1;
    tcEvClr[2] = 1'b1;
    @(negedge clk);
    tcEvClr = '0;
    doRead(2'b11, 0, "collide");
    checkVal("collide_const", 32'(tcRdData), 32'h004);

    // reset during CAPTURE aborts the read
    @(negedge clk);
    tcRdReq = 1'b1; tcRdSel = 2'b00; tcRdAddr = 4'd5;
    @(negedge clk);
    tcRdReq = 1'b0;
    reset = 1'b0;
    #1;
    checkVal("midrst_busy", 32'(tcRdBusy), 32'd0);
    checkVal("midrst_data", 32'(tcRdData), 32'd0);
    vCount = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (tcRdValid) vCount++;
    end
    checkVal("midrst_no_valid", 32'(vCount), 32'd0);
    reset = 1'b1;
    doRead(2'b00, 5, "after_rst");
    checkVal("after_rst_const", 32'(tcRdData), 32'h0A7);

    // randomized reads against the model
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < TC_NUM; i++) begin
        presetArr[i] = DATA_W'($urandom);
        accArr[i]    = DATA_W'($urandom);
      end
      enIn = TC_NUM'($urandom);
      for (int c = 0; c < int'($urandom_range(1, 4)); c++) begin
        @(negedge clk);
        checkVal("rnd_any", 32'(tcEventAny), 32'(mAny));
        doneIn  = TC_NUM'($urandom);
        tcEvClr = TC_NUM'($urandom & $urandom);
      end
      @(negedge clk);
      tcEvClr = '0;
      doRead(2'($urandom), int'($urandom_range(0, TC_NUM - 1)), "rnd");
      held = tcRdData;
      @(negedge clk);
      checkVal("rnd_hold", 32'(tcRdData), 32'(held));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
